quant_block_sequencer: RTL and testbench

Sequences 8x8 blocks of DCT coefficients through the quantizer datapath (quant ROM + quantizer), which has a fixed pipeline latency and no stall input. Accepts coefficients over a valid/ready stream, drives the coefficient index and value into the quantizer, and realigns the results with their index. Results go to a small output buffer. Credit-based issue guarantees that downstream backpressure never drops a quantized value. Sits between the 2-D DCT stage and the zigzag/entropy stage.

---
 rtl/quant_block_sequencer_if.sv | 33 +++
 rtl/quant_block_sequencer.sv | 194 +++++++++++++++++++
 tb/tb_quant_block_sequencer.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/quant_block_sequencer_if.sv
// Stream and quantizer-side bundle for quant_block_sequencer.
//   s_*  : coefficient input stream (valid/ready), raster order within a block
//   q_*  : drive to / result from the fixed-latency quantizer datapath
//   m_*  : quantized output stream (valid/ready) with raster index and last flag
// Modports: slave = sequencer side, master = environment side.
interface quant_block_sequencer_if #(
  parameter int unsigned COEF_W = 12,
  parameter int unsigned Q_W    = 8
) ();
  logic                     s_valid;
  logic                     s_ready;
  logic signed [COEF_W-1:0] s_data;

  logic [5:0]               q_addr;
  logic signed [COEF_W-1:0] q_dct;
  logic signed [Q_W-1:0]    q_out;

  logic                     m_valid;
  logic                     m_ready;
  logic signed [Q_W-1:0]    m_data;
  logic [5:0]               m_index;
  logic                     m_last;

  modport slave (
    input  s_valid, s_data, q_out, m_ready,
    output s_ready, q_addr, q_dct, m_valid, m_data, m_index, m_last
  );

  modport master (
    output s_valid, s_data, q_out, m_ready,
    input  s_ready, q_addr, q_dct, m_valid, m_data, m_index, m_last
  );
endinterface

// File: rtl/quant_block_sequencer.sv
// Sequences 8x8 blocks of DCT coefficients through a fixed-latency quantizer
// that cannot stall, realigns results with their raster index and buffers them
// in a small FWFT FIFO. Issue is credit-gated so a result always has a slot.
// Ports:
//   clk, rst   : rising-edge clock, synchronous active-high reset
//   en         : run enable, honoured only at block boundaries
//   bus        : s_* input stream, q_* quantizer drive/result, m_* output stream
//   blk_done   : one-cycle pulse after index 63 is accepted downstream
//   blk_count  : blocks fully output since reset (wraps)
//   busy       : sequencer not idle
module quant_block_sequencer #(
  parameter int unsigned COEF_W     = 12,
  parameter int unsigned Q_W        = 8,
  parameter int unsigned QLAT       = 1,
  parameter int unsigned OBUF_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  quant_block_sequencer_if.slave        bus,
  output logic                          blk_done,
  output logic [15:0]                   blk_count,
  output logic                          busy
);

  localparam int unsigned IDX_W    = 6;
  localparam int unsigned PTR_W    = $clog2(OBUF_DEPTH);
  localparam int unsigned CNT_W    = $clog2(OBUF_DEPTH + 1);
  localparam int unsigned IF_W     = $clog2(QLAT + 1);
  localparam int unsigned SUM_W    = CNT_W + 1;
  localparam int unsigned LAST_STG = QLAT - 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  localparam logic [IDX_W-1:0] IDX_LAST = 6'd63;

  logic [1:0]              r_state;
  logic [1:0]              w_state_nxt;
  logic [IDX_W-1:0]        r_idx;

  logic                    r_trk_vld [QLAT];
  logic [IDX_W-1:0]        r_trk_idx [QLAT];
  logic [IF_W-1:0]         r_inflight;

  logic [Q_W-1:0]          r_mem_data [OBUF_DEPTH];
  logic [IDX_W-1:0]        r_mem_idx  [OBUF_DEPTH];
  logic                    r_mem_last [OBUF_DEPTH];
  logic [PTR_W-1:0]        r_wr_ptr;
  logic [PTR_W-1:0]        r_rd_ptr;
  logic [CNT_W-1:0]        r_fifo_count;

  logic                    r_blk_done;
  logic [15:0]             r_blk_count;
  logic                    r_busy;

  logic                    w_s_ready;
  logic                    w_issue;
  logic                    w_capture;
  logic                    w_m_valid;
  logic                    w_pop;
  logic [SUM_W-1:0]        w_credit_used;
  logic [COEF_W-1:0]       w_dct;
  logic [IDX_W-1:0]        w_cap_idx;

  // Credits count both buffered results and those still inside the quantizer,
  // so every issued coefficient already owns a buffer slot.
  assign w_credit_used = SUM_W'(r_fifo_count) + SUM_W'(r_inflight);
  assign w_s_ready     = (r_state == ST_RUN) && (w_credit_used < SUM_W'(OBUF_DEPTH));
  assign w_issue       = bus.s_valid && w_s_ready;
  assign w_capture     = r_trk_vld[LAST_STG];
  assign w_cap_idx     = r_trk_idx[LAST_STG];
  assign w_m_valid     = (r_fifo_count != '0);
  assign w_pop         = w_m_valid && bus.m_ready;
  assign w_dct         = bus.s_data;

  assign bus.s_ready   = w_s_ready;
  assign bus.q_addr    = r_idx;
  assign bus.q_dct     = w_dct;
  assign bus.m_valid   = w_m_valid;
  assign bus.m_data    = r_mem_data[r_rd_ptr];
  assign bus.m_index   = r_mem_idx[r_rd_ptr];
  assign bus.m_last    = r_mem_last[r_rd_ptr];

  assign blk_done      = r_blk_done;
  assign blk_count     = r_blk_count;
  assign busy          = r_busy;

  // Next-state logic: en is only looked at on entry and on the last issue of a block.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (en) begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (w_issue && (r_idx == IDX_LAST) && !en) begin
          w_state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if ((r_inflight == '0) && (r_fifo_count == '0)) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State register, coefficient index and busy flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt != ST_IDLE);
      if (r_state == ST_IDLE) begin
        r_idx <= '0;
      end else if (w_issue) begin
        r_idx <= r_idx + IDX_W'(1);
      end
    end
  end

  // In-flight tracker mirrors the quantizer pipeline so results pair with their index.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < QLAT; i++) begin
        r_trk_vld[i] <= 1'b0;
        r_trk_idx[i] <= '0;
      end
      r_inflight <= '0;
    end else begin
      r_trk_vld[0] <= w_issue;
      r_trk_idx[0] <= r_idx;
      for (int i = 1; i < QLAT; i++) begin
        r_trk_vld[i] <= r_trk_vld[i-1];
        r_trk_idx[i] <= r_trk_idx[i-1];
      end
      r_inflight <= r_inflight + IF_W'(w_issue) - IF_W'(w_capture);
    end
  end

  // Output buffer storage; pointers and count alone define its contents.
  always_ff @(posedge clk) begin
    if (w_capture) begin
      r_mem_data[r_wr_ptr] <= bus.q_out;
      r_mem_idx[r_wr_ptr]  <= w_cap_idx;
      r_mem_last[r_wr_ptr] <= (w_cap_idx == IDX_LAST);
    end
  end

  // Output buffer pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_fifo_count <= '0;
    end else begin
      if (w_capture) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_capture, w_pop})
        2'b10:   r_fifo_count <= r_fifo_count + CNT_W'(1);
        2'b01:   r_fifo_count <= r_fifo_count - CNT_W'(1);
        default: r_fifo_count <= r_fifo_count;
      endcase
    end
  end

  // Block completion: counted when the last coefficient leaves downstream.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_blk_done  <= 1'b0;
      r_blk_count <= '0;
    end else begin
      r_blk_done <= w_pop && bus.m_last;
      if (w_pop && bus.m_last) begin
        r_blk_count <= r_blk_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_quant_block_sequencer.sv
// Scoreboard bench for quant_block_sequencer with a registered q_addr+1 quantizer stub.
module tb_quant_block_sequencer;

  localparam int unsigned COEF_W = 12;
  localparam int unsigned Q_W    = 8;
  localparam int unsigned QLAT   = 1;
  localparam int unsigned DEPTH  = 4;

  typedef struct {
    logic [Q_W-1:0] data;
    logic [5:0]     idx;
    logic           last;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        blk_done;
  logic [15:0] blk_count;
  logic        busy;

  quant_block_sequencer_if #(.COEF_W(COEF_W), .Q_W(Q_W)) bus ();

  quant_block_sequencer #(
    .COEF_W(COEF_W), .Q_W(Q_W), .QLAT(QLAT), .OBUF_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .bus(bus),
    .blk_done(blk_done), .blk_count(blk_count), .busy(busy)
  );

  always #5 clk = ~clk;

  // Quantizer stub: one-cycle registered result equal to index + 1.
  always_ff @(posedge clk) bus.q_out <= Q_W'(bus.q_addr) + Q_W'(1);

  int   n_vec = 0;
  int   n_err = 0;
  int   n_acc = 0;
  int   n_pop = 0;
  int   m_idx = 0;
  int   exp_cnt = 0;
  logic exp_done = 1'b0;
  exp_t sb[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Input monitor: model the raster index per accept and push the expected result.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (rst) begin
        m_idx = 0;
      end else if (bus.s_valid && bus.s_ready) begin
        sb.push_back('{data: Q_W'(m_idx + 1), idx: 6'(m_idx), last: (m_idx == 63)});
        check("q_addr", 32'(bus.q_addr), 32'(m_idx));
        check("q_dct", 32'(bus.q_dct), 32'(bus.s_data));
        check("credit", 32'(sb.size() <= DEPTH), 32'd1);
        m_idx = (m_idx + 1) % 64;
        n_acc++;
      end
    end
  end

  // Output monitor: pop and compare on every output handshake; track block counters.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (rst) begin
        sb.delete();
        exp_done = 1'b0;
        exp_cnt  = 0;
      end else begin
        check("blk_done", 32'(blk_done), 32'(exp_done));
        check("blk_count", 32'(blk_count), 32'(exp_cnt % 65536));
        exp_done = 1'b0;
        if (bus.m_valid && bus.m_ready) begin
          n_pop++;
          if (sb.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL spurious_output: index %0d with empty scoreboard", bus.m_index);
          end else begin
            e = sb.pop_front();
            check("m_data", 32'(bus.m_data), 32'(e.data));
            check("m_index", 32'(bus.m_index), 32'(e.idx));
            check("m_last", 32'(bus.m_last), 32'(e.last));
            if (e.last) begin
              exp_done = 1'b1;
              exp_cnt++;
            end
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int t;
    en          = 1'b0;
    bus.s_valid = 1'b0;
    bus.m_ready = 1'b1;
    t = 0;
    while (t < 400) begin
      @(negedge clk);
      if (!busy && !bus.m_valid) break;
      t++;
    end
    if (t >= 400) begin
      n_vec++;
      n_err++;
      $display("FAIL %s: timeout waiting for idle, busy=%0d m_valid=%0d", name, busy, bus.m_valid);
    end
    repeat (2) @(negedge clk);
  endtask

  // Stream up to `target` accepts with m_ready=1, dropping en after the first beat.
  task automatic run_block(input int target, input string name);
    int base, t;
    base = n_acc;
    en = 1'b1;
    bus.s_valid = 1'b1;
    bus.m_ready = 1'b1;
    bus.s_data  = COEF_W'($urandom);
    t = 0;
    while ((n_acc - base) < target && t < 400) begin
      @(negedge clk);
      t++;
      if ((n_acc - base) >= 1) en = 1'b0;
      bus.s_data = COEF_W'($urandom);
    end
    bus.s_valid = 1'b0;
    check({name, "_accepts"}, 32'(n_acc - base), 32'(target));
  endtask

  initial begin
    int base, pbase, it, acc_it, tf, tl;

    rst = 1'b1; en = 1'b0;
    bus.s_valid = 1'b0; bus.s_data = '0; bus.m_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_s_ready", 32'(bus.s_ready), 32'd0);
    check("rst_m_valid", 32'(bus.m_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_blk_count", 32'(blk_count), 32'd0);

    // Single block, IDLE->RUN latency, drain back to idle.
    @(negedge clk);
    en = 1'b1;
    @(negedge clk);
    #1;
    check("run_s_ready", 32'(bus.s_ready), 32'd1);
    check("run_busy", 32'(busy), 32'd1);
    run_block(64, "single");
    wait_idle("single");
    check("single_blk_count", 32'(blk_count), 32'd1);
    check("single_busy", 32'(busy), 32'd0);

    // Backpressure: exactly DEPTH accepts, then credit returns one cycle after a pop.
    @(negedge clk);
    en = 1'b1; bus.m_ready = 1'b0; bus.s_valid = 1'b1;
    base = n_acc;
    repeat (12) begin
      @(negedge clk);
      bus.s_data = COEF_W'($urandom);
    end
    check("bp_accepts", 32'(n_acc - base), 32'(DEPTH));
    #1;
    check("bp_s_ready_low", 32'(bus.s_ready), 32'd0);
    bus.m_ready = 1'b1;
    en = 1'b0;
    @(negedge clk);
    #1;
    check("bp_s_ready_back", 32'(bus.s_ready), 32'd1);
    it = 0;
    while ((n_acc - base) < 64 && it < 400) begin
      @(negedge clk);
      bus.s_data = COEF_W'($urandom);
      it++;
    end
    check("bp_total", 32'(n_acc - base), 32'd64);
    wait_idle("bp");
    check("bp_blk_count", 32'(blk_count), 32'd2);

    // Random stalls over ten blocks.
    do_reset();
    en = 1'b1;
    base = n_acc;
    it = 0;
    while ((n_acc - base) < 640 && it < 8000) begin
      @(negedge clk);
      it++;
      if ((n_acc - base) > 576) en = 1'b0;
      bus.s_valid = 1'($urandom % 2);
      bus.m_ready = 1'($urandom % 2);
      bus.s_data  = COEF_W'($urandom);
    end
    bus.s_valid = 1'b0;
    check("rnd_accepts", 32'(n_acc - base), 32'd640);
    wait_idle("rnd");
    check("rnd_blk_count", 32'(blk_count), 32'd10);

    // Back-to-back blocks: no bubble on input or output.
    do_reset();
    en = 1'b1; bus.s_valid = 1'b1; bus.m_ready = 1'b1;
    @(negedge clk);
    base = n_acc; pbase = n_pop;
    it = 0; acc_it = -1; tf = -1; tl = -1;
    while (tl < 0 && it < 400) begin
      @(negedge clk);
      it++;
      if ((n_acc - base) >= 65) en = 1'b0;
      if ((n_acc - base) >= 128 && acc_it < 0) begin
        acc_it = it;
        bus.s_valid = 1'b0;
      end
      if ((n_pop - pbase) >= 1 && tf < 0) tf = it;
      if ((n_pop - pbase) >= 128) tl = it;
      bus.s_data = COEF_W'($urandom);
    end
    check("b2b_accept_cycles", 32'(acc_it), 32'd128);
    check("b2b_output_span", 32'(tl - tf + 1), 32'd128);
    wait_idle("b2b");
    check("b2b_blk_count", 32'(blk_count), 32'd2);

    // en dropped at idx 20: block completes, then no further accepts.
    do_reset();
    en = 1'b1; bus.s_valid = 1'b1; bus.m_ready = 1'b1;
    base = n_acc;
    repeat (200) begin
      @(negedge clk);
      if ((n_acc - base) >= 21) en = 1'b0;
      bus.s_data = COEF_W'($urandom);
    end
    check("endrop_accepts", 32'(n_acc - base), 32'd64);
    #1;
    check("endrop_busy", 32'(busy), 32'd0);
    check("endrop_s_ready", 32'(bus.s_ready), 32'd0);
    check("endrop_blk_count", 32'(blk_count), 32'd1);
    bus.s_valid = 1'b0;

    // Reset mid-block with results still buffered.
    @(negedge clk);
    en = 1'b1; bus.s_valid = 1'b1; bus.m_ready = 1'b1;
    base = n_acc;
    it = 0;
    while ((n_acc - base) < 30 && it < 200) begin
      @(negedge clk);
      it++;
      if ((n_acc - base) >= 28) bus.m_ready = 1'b0;
      bus.s_data = COEF_W'($urandom);
    end
    bus.s_valid = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("mid_buffered", 32'(bus.m_valid), 32'd1);
    @(negedge clk);
    rst = 1'b1; en = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("mid_rst_m_valid", 32'(bus.m_valid), 32'd0);
    check("mid_rst_s_ready", 32'(bus.s_ready), 32'd0);
    check("mid_rst_blk_count", 32'(blk_count), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    run_block(64, "post_rst");
    wait_idle("post_rst");
    check("post_rst_blk_count", 32'(blk_count), 32'd1);
    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
